store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, 2..16); entry count.
REQ-002 SHALL have ports, in order:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enq_valid_i  in  1  MEM-stage store allocation request.
- enq_addr_i  in  32  physical byte address.
- enq_data_i  in  32  store data.
- enq_wstrb_i  in  4  byte strobes.
- enq_ready_o  out  1  free entry available.
- commit_i  in  1  WB commits oldest uncommitted store.
- cancel_i  in  1  WB cancels its store.
- flush_i  in  1  WB pipeline flush.
- wr_req_o  out  1  committed store ready for dcache.
- wr_addr_o  out  32  dcache write address.
- wr_data_o  out  32  dcache write data.
- wr_wstrb_o  out  4  dcache write strobes.
- wr_ack_i  in  1  dcache accepted head entry.
- ld_addr_i  in  32  load address for hazard check.
- ld_conflict_o  out  1  load must stall.
- fwd_hit_o  out  1  full-word forward valid.
- fwd_data_o  out  32  forwarded data.
- empty_o  out  1  no valid entries.

Function
REQ-003 SHALL hold a circular queue: head (oldest, drain), cmt (oldest uncommitted), tail (next free); committed region [head,cmt), speculative region [cmt,tail).
REQ-004 SHALL track total count and committed count; pointers wrap modulo DEPTH.
REQ-005 enq_ready_o SHALL be 1 when count < DEPTH, combinational from registered state.
REQ-006 enq fires when enq_valid_i & enq_ready_o & ~flush_i & ~cancel_i; writes entry at tail, tail+1 next cycle.
REQ-007 commit_i SHALL advance cmt by one if speculative count > 0; ignored otherwise.
REQ-008 flush_i or cancel_i SHALL set tail to cmt after applying same-cycle commit, discarding all speculative entries; enq that cycle is dropped.
REQ-009 wr_req_o SHALL be 1 when committed count > 0; wr_addr/data/wstrb SHALL show the head entry and stay stable until wr_ack_i.
REQ-010 wr_ack_i with wr_req_o SHALL advance head by one; wr_ack_i without wr_req_o SHALL be ignored.
REQ-011 Same-cycle enq, commit, ack SHALL all take effect; count += enq - ack; committed count += commit - ack.
REQ-012 Full (count==DEPTH) with same-cycle ack SHALL still deassert enq_ready_o that cycle; new entry accepted next cycle.
REQ-013 Flush/cancel SHALL never drop committed entries; they drain normally.
REQ-014 ld_conflict_o SHALL be 1 when any valid entry has addr[31:2]==ld_addr_i[31:2] and non-zero wstrb, subject to REQ-019.
REQ-015 empty_o SHALL be 1 when count==0.
REQ-016 Read latency: enqueued entry visible on wr_* earliest 1 cycle after its commit_i cycle.

Reset
REQ-017 rst_n low SHALL asynchronously clear head, cmt, tail, counts, entry valid bits; entry payload not reset.
REQ-018 Reset outputs: enq_ready_o=1, wr_req_o=0, wr_addr/data/wstrb=0, ld_conflict_o=0, fwd_hit_o=0, fwd_data_o=0, empty_o=1; reset mid-drain discards all entries without completing.

Configuration
REQ-019 Macro STORE_BUFFER_FWD_EN: defined -> youngest matching entry with wstrb==4'hF gives fwd_hit_o=1, fwd_data_o=its data, ld_conflict_o=0; youngest match partial -> ld_conflict_o=1, fwd_hit_o=0.
REQ-020 Undefined -> fwd_hit_o and fwd_data_o tied 0; any match asserts ld_conflict_o.

Verification
REQ-021 Enq addr 0x1000 data 0xAABBCCDD wstrb F, commit next cycle, wr_ack_i held 0 -> wr_req_o=1 with those values, stable for 5 cycles; ack -> empty_o=1 next cycle.
REQ-022 Enq 4 stores, no commit -> enq_ready_o=0; 5th enq_valid_i ignored; flush_i -> empty_o=1, enq_ready_o=1 next cycle.
REQ-023 Enq A,B,C; commit A with flush_i same cycle -> only A drains, count=1.
REQ-024 Full, all committed, ack and enq same cycle -> count stays 4; pointers wrap, drain order preserved for 8 stores.
REQ-025 Entry addr 0x2004 wstrb F data 0x12345678, load 0x2006 -> FWD_EN: fwd_hit_o=1, data 0x12345678; without: ld_conflict_o=1; wstrb 4'h3 -> ld_conflict_o=1 in both.
REQ-026 rst_n low while wr_req_o=1 -> wr_req_o=0, empty_o=1 immediately.

Source files
------------

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Circular store queue between MEM and the data cache. Stores are allocated
//   speculatively at the tail, become committed when WB commits them (the
//   cmt pointer), and drain from the head to the dcache one at a time.
//   Regions: committed = [head, cmt), speculative = [cmt, tail).
//   Loads are checked against all valid entries for address hazards.
//
//   Optional feature macro: STORE_BUFFER_FWD_EN
//     defined   -> youngest matching full-word (wstrb 4'hF) entry forwards its
//                  data; a youngest partial match stalls the load.
//     undefined -> no forwarding; any match stalls the load.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   enq_*_i / enq_ready_o  store allocation from MEM
//   commit_i, cancel_i, flush_i  WB control
//   wr_*_o, wr_ack_i    head-entry write to dcache
//   ld_addr_i           load address for hazard check
//   ld_conflict_o       load must stall
//   fwd_hit_o/fwd_data_o full-word forward result
//   empty_o             no valid entries
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enq_valid_i,
    input  logic [31:0] enq_addr_i,
    input  logic [31:0] enq_data_i,
    input  logic [3:0]  enq_wstrb_i,
    output logic        enq_ready_o,
    input  logic        commit_i,
    input  logic        cancel_i,
    input  logic        flush_i,
    output logic        wr_req_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_wstrb_o,
    input  logic        wr_ack_i,
    input  logic [31:0] ld_addr_i,
    output logic        ld_conflict_o,
    output logic        fwd_hit_o,
    output logic [31:0] fwd_data_o,
    output logic        empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]    head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d, ccount_q, ccount_d;
    logic [CW-1:0]    spec_cnt;
    logic [DEPTH-1:0] valid_q, valid_d;

    // Payload storage; never reset, qualified by valid_q.
    logic [31:0] addr_mem  [DEPTH];
    logic [31:0] data_mem  [DEPTH];
    logic [3:0]  wstrb_mem [DEPTH];

    logic enq_fire, commit_fire, ack_fire, drop_spec;

    assign enq_ready_o = (count_q < DEPTH_C);
    assign empty_o     = (count_q == '0);
    assign wr_req_o    = (ccount_q != '0);
    assign spec_cnt    = count_q - ccount_q;

    assign drop_spec   = flush_i | cancel_i;
    assign enq_fire    = enq_valid_i & enq_ready_o & ~drop_spec;
    assign commit_fire = commit_i & (spec_cnt != '0);
    assign ack_fire    = wr_ack_i & wr_req_o;

    always_comb begin
        head_d   = head_q + PW'(ack_fire);
        cmt_d    = cmt_q + PW'(commit_fire);
        ccount_d = ccount_q + CW'(commit_fire) - CW'(ack_fire);
        tail_d   = tail_q + PW'(enq_fire);
        count_d  = count_q + CW'(enq_fire) - CW'(ack_fire);
        if (drop_spec) begin
            // Speculative region collapses onto the post-commit cmt pointer.
            tail_d  = cmt_d;
            count_d = ccount_d;
        end
    end

    // An entry is valid iff its age offset from the new head is below the
    // new count; this clears drained and discarded entries uniformly.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            logic [PW-1:0] offset;
            assign offset      = PW'(gi) - head_d;
            assign valid_d[gi] = ({1'b0, offset} < count_d);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            cmt_q    <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            ccount_q <= '0;
            valid_q  <= '0;
        end else begin
            head_q   <= head_d;
            cmt_q    <= cmt_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            ccount_q <= ccount_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            addr_mem[tail_q]  <= enq_addr_i;
            data_mem[tail_q]  <= enq_data_i;
            wstrb_mem[tail_q] <= enq_wstrb_i;
        end
    end

    // Head entry cannot be overwritten while committed: tail only reaches
    // head when full, and enq is blocked when full.
    assign wr_addr_o  = wr_req_o ? addr_mem[head_q]  : '0;
    assign wr_data_o  = wr_req_o ? data_mem[head_q]  : '0;
    assign wr_wstrb_o = wr_req_o ? wstrb_mem[head_q] : '0;

    logic [DEPTH-1:0] match;
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_q[gi]
                             && (addr_mem[gi][31:2] == ld_addr_i[31:2])
                             && (wstrb_mem[gi] != 4'h0);
        end
    endgenerate

`ifdef STORE_BUFFER_FWD_EN
    logic          found;
    logic [PW-1:0] young_idx;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        found     = 1'b0;
        young_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match[head_q + PW'(k)]) begin
                found     = 1'b1;
                young_idx = head_q + PW'(k);
            end
        end
    end

    assign fwd_hit_o     = found && (wstrb_mem[young_idx] == 4'hF);
    assign ld_conflict_o = found && (wstrb_mem[young_idx] != 4'hF);
    assign fwd_data_o    = fwd_hit_o ? data_mem[young_idx] : '0;
`else
    assign ld_conflict_o = |match;
    assign fwd_hit_o     = 1'b0;
    assign fwd_data_o    = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enq_valid_i;
    logic [31:0] enq_addr_i, enq_data_i;
    logic [3:0]  enq_wstrb_i;
    logic        enq_ready_o;
    logic        commit_i, cancel_i, flush_i;
    logic        wr_req_o;
    logic [31:0] wr_addr_o, wr_data_o;
    logic [3:0]  wr_wstrb_o;
    logic        wr_ack_i;
    logic [31:0] ld_addr_i;
    logic        ld_conflict_o, fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic        empty_o;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid_i(enq_valid_i), .enq_addr_i(enq_addr_i),
        .enq_data_i(enq_data_i), .enq_wstrb_i(enq_wstrb_i),
        .enq_ready_o(enq_ready_o),
        .commit_i(commit_i), .cancel_i(cancel_i), .flush_i(flush_i),
        .wr_req_o(wr_req_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .wr_wstrb_o(wr_wstrb_o), .wr_ack_i(wr_ack_i),
        .ld_addr_i(ld_addr_i), .ld_conflict_o(ld_conflict_o),
        .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of live stores plus number of committed ones.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;
    ent_t mq[$];
    int   m_cmt;

    int n_vec = 0;
    int n_err = 0;

    task automatic drive(input bit ev, input [31:0] ea, input [31:0] ed,
                         input [3:0] ew, input bit cm, input bit cn,
                         input bit fl, input bit ak);
        enq_valid_i = ev; enq_addr_i = ea; enq_data_i = ed; enq_wstrb_i = ew;
        commit_i = cm; cancel_i = cn; flush_i = fl; wr_ack_i = ak;
    endtask

    // Advance one clock, updating the model from the inputs currently driven.
    task automatic clk_step();
        int   sz;
        bit   e_f, c_f, a_f, drop;
        ent_t e;
        sz   = mq.size();
        drop = flush_i || cancel_i;
        e_f  = enq_valid_i && (sz < DEPTH) && !drop;
        c_f  = commit_i && (sz > m_cmt);
        a_f  = wr_ack_i && (m_cmt > 0);
        e    = '{a: enq_addr_i, d: enq_data_i, s: enq_wstrb_i};
        @(posedge clk);
        if (a_f) begin void'(mq.pop_front()); m_cmt--; end
        if (c_f) m_cmt++;
        if (drop) begin
            while (mq.size() > m_cmt) void'(mq.pop_back());
        end else if (e_f) begin
            mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic cycle(input bit ev, input [31:0] ea, input [31:0] ed,
                         input [3:0] ew, input bit cm, input bit cn,
                         input bit fl, input bit ak);
        drive(ev, ea, ed, ew, cm, cn, fl, ak);
        clk_step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Youngest-match rule evaluated over the model queue.
    function automatic void model_ld(input [31:0] la, output bit conf,
                                     output bit hit, output [31:0] fd);
        bit   any;
        ent_t y;
        any = 0; y = '0;
        foreach (mq[i])
            if (mq[i].a[31:2] == la[31:2] && mq[i].s != 4'h0) begin
                any = 1; y = mq[i];
            end
`ifdef STORE_BUFFER_FWD_EN
        hit  = any && (y.s == 4'hF);
        conf = any && (y.s != 4'hF);
        fd   = hit ? y.d : 32'h0;
`else
        hit  = 0;
        conf = any;
        fd   = 32'h0;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        ld_addr_i = 32'h0;
        mq.delete(); m_cmt = 0;
        @(negedge clk); #1;
        n_vec++;
        if ({enq_ready_o, wr_req_o, ld_conflict_o, fwd_hit_o, empty_o} !== 5'b10001) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 10001",
                     {enq_ready_o, wr_req_o, ld_conflict_o, fwd_hit_o, empty_o});
        end
        n_vec++;
        if ({wr_addr_o, wr_data_o, wr_wstrb_o, fwd_data_o} !== 100'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected zeros",
                     wr_addr_o, wr_data_o, wr_wstrb_o, fwd_data_o);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_drain_stable();
        cycle(1, 32'h1000, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0);
        n_vec++;
        if (wr_req_o !== 1'b0) begin
            n_err++; $display("FAIL drain_latency: wr_req %b expected 0", wr_req_o);
        end
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({wr_req_o, wr_addr_o, wr_data_o, wr_wstrb_o} !== {1'b1, 32'h1000, 32'hAABBCCDD, 4'hF}) begin
                n_err++;
                $display("FAIL drain_stable[%0d]: got %b %h %h %h expected 1 00001000 aabbccdd f",
                         i, wr_req_o, wr_addr_o, wr_data_o, wr_wstrb_o);
            end
            cycle(0, 0, 0, 0, 0, 0, 0, 0);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        n_vec++;
        if ({empty_o, wr_req_o} !== 2'b10) begin
            n_err++; $display("FAIL drain_empty: empty/wr_req %b expected 10", {empty_o, wr_req_o});
        end
    endtask

    task automatic test_full_flush();
        for (int i = 0; i < 4; i++)
            cycle(1, 32'h3000 + 32'(i * 4), 32'(i), 4'hF, 0, 0, 0, 0);
        n_vec++;
        if (enq_ready_o !== 1'b0) begin
            n_err++; $display("FAIL full_ready: got %b expected 0", enq_ready_o);
        end
        cycle(1, 32'h3100, 32'h55, 4'hF, 0, 0, 0, 0);
        n_vec++;
        if ({enq_ready_o, empty_o} !== 2'b00) begin
            n_err++; $display("FAIL full_5th: ready/empty %b expected 00", {enq_ready_o, empty_o});
        end
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        n_vec++;
        if ({enq_ready_o, empty_o, wr_req_o} !== 3'b110) begin
            n_err++; $display("FAIL full_flush: ready/empty/wr_req %b expected 110",
                              {enq_ready_o, empty_o, wr_req_o});
        end
    endtask

    task automatic test_commit_flush();
        cycle(1, 32'h4000, 32'hA, 4'hF, 0, 0, 0, 0);
        cycle(1, 32'h4004, 32'hB, 4'hF, 0, 0, 0, 0);
        cycle(1, 32'h4008, 32'hC, 4'hF, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 1, 0);
        ld_addr_i = 32'h4004; #1;
        n_vec++;
        if ({wr_req_o, wr_data_o, ld_conflict_o, fwd_hit_o} !== {1'b1, 32'hA, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL commit_flush_head: got %b %h %b %b expected 1 0000000a 0 0",
                              wr_req_o, wr_data_o, ld_conflict_o, fwd_hit_o);
        end
        ld_addr_i = 32'h0;
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        n_vec++;
        if (empty_o !== 1'b1) begin
            n_err++; $display("FAIL commit_flush_count: empty %b expected 1", empty_o);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_d[8];
        int pi, di;
        for (int i = 0; i < 8; i++) exp_d[i] = $urandom;
        for (int i = 0; i < 4; i++)
            cycle(1, 32'h5000 + 32'(i * 4), exp_d[i], 4'hF, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0);
        pi = 4; di = 0;
        for (int c = 0; c < 60 && di < 8; c++) begin
            drive(pi < 8, 32'h5000 + 32'(pi * 4), exp_d[pi % 8], 4'hF, 1, 0, 0, wr_req_o);
            #1;
            n_vec++;
            if (enq_ready_o !== (mq.size() < DEPTH)) begin
                n_err++; $display("FAIL wrap_ready: got %b expected %b", enq_ready_o, mq.size() < DEPTH);
            end
            if (wr_ack_i) begin
                n_vec++;
                if (wr_data_o !== exp_d[di]) begin
                    n_err++; $display("FAIL wrap_order[%0d]: got %h expected %h", di, wr_data_o, exp_d[di]);
                end
                di++;
            end
            if (enq_valid_i && mq.size() < DEPTH) pi++;
            clk_step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (di != 8) begin
            n_err++; $display("FAIL wrap_timeout: drained %0d expected 8", di);
        end
    endtask

    task automatic test_forward();
        cycle(1, 32'h2004, 32'h12345678, 4'hF, 0, 0, 0, 0);
        ld_addr_i = 32'h2006; #1;
        n_vec++;
`ifdef STORE_BUFFER_FWD_EN
        if ({fwd_hit_o, fwd_data_o, ld_conflict_o} !== {1'b1, 32'h12345678, 1'b0}) begin
            n_err++; $display("FAIL fwd_full: got %b %h %b expected 1 12345678 0",
                              fwd_hit_o, fwd_data_o, ld_conflict_o);
        end
`else
        if ({fwd_hit_o, fwd_data_o, ld_conflict_o} !== {1'b0, 32'h0, 1'b1}) begin
            n_err++; $display("FAIL fwd_full: got %b %h %b expected 0 00000000 1",
                              fwd_hit_o, fwd_data_o, ld_conflict_o);
        end
`endif
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 32'h2004, 32'h12345678, 4'h3, 0, 0, 0, 0);
        #1;
        n_vec++;
        if ({fwd_hit_o, ld_conflict_o} !== 2'b01) begin
            n_err++; $display("FAIL fwd_partial: hit/conflict %b expected 01", {fwd_hit_o, ld_conflict_o});
        end
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        #1;
        n_vec++;
        if (ld_conflict_o !== 1'b0) begin
            n_err++; $display("FAIL fwd_cancelled: conflict %b expected 0", ld_conflict_o);
        end
        ld_addr_i = 32'h0;
    endtask

    task automatic test_random();
        bit          ec, eh;
        logic [31:0] ed;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 6,
                  32'h2000 | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3)),
                  $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
            ld_addr_i = 32'h2000 | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
            #1;
            model_ld(ld_addr_i, ec, eh, ed);
            n_vec++;
            if ({enq_ready_o, empty_o, wr_req_o} !== {mq.size() < DEPTH, mq.size() == 0, m_cmt > 0}) begin
                n_err++; $display("FAIL rnd_flags[%0d]: got %b expected %b", c,
                                  {enq_ready_o, empty_o, wr_req_o},
                                  {mq.size() < DEPTH, mq.size() == 0, m_cmt > 0});
            end
            if (m_cmt > 0) begin
                n_vec++;
                if ({wr_addr_o, wr_data_o, wr_wstrb_o} !== {mq[0].a, mq[0].d, mq[0].s}) begin
                    n_err++; $display("FAIL rnd_head[%0d]: got %h %h %h expected %h %h %h", c,
                                      wr_addr_o, wr_data_o, wr_wstrb_o, mq[0].a, mq[0].d, mq[0].s);
                end
            end
            n_vec++;
            if ({ld_conflict_o, fwd_hit_o, fwd_data_o} !== {ec, eh, ed}) begin
                n_err++; $display("FAIL rnd_load[%0d]: got %b %b %h expected %b %b %h", c,
                                  ld_conflict_o, fwd_hit_o, fwd_data_o, ec, eh, ed);
            end
            clk_step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        ld_addr_i = 32'h0;
    endtask

    task automatic test_reset_mid_drain();
        cycle(1, 32'h6000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        n_vec++;
        if (wr_req_o !== 1'b1) begin
            n_err++; $display("FAIL mid_drain_req: got %b expected 1", wr_req_o);
        end
        #2 rst_n = 1'b0;
        #1;
        mq.delete(); m_cmt = 0;
        n_vec++;
        if ({wr_req_o, empty_o, wr_data_o} !== {1'b0, 1'b1, 32'h0}) begin
            n_err++; $display("FAIL mid_drain_reset: got %b %b %h expected 0 1 00000000",
                              wr_req_o, empty_o, wr_data_o);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({wr_req_o, empty_o, enq_ready_o} !== 3'b011) begin
            n_err++; $display("FAIL mid_drain_after: got %b expected 011",
                              {wr_req_o, empty_o, enq_ready_o});
        end
    endtask

    initial begin
        test_reset();
        test_drain_stable();
        test_full_flush();
        test_commit_flush();
        test_wrap();
        test_forward();
        test_random();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
